// File: rtl/exu_pkg.sv
// Shared definitions for the multi-cycle execute stage.
// Holds the M-extension funct3 codes, the M-unit FSM state enum, and the
// operand-select, Alu and branch encodings carried over from the
// single-cycle execute unit.
package exu_pkg;

  // RV32M/RV64M funct3
  localparam logic [2:0] MF_MUL    = 3'd0;
  localparam logic [2:0] MF_MULH   = 3'd1;
  localparam logic [2:0] MF_MULHSU = 3'd2;
  localparam logic [2:0] MF_MULHU  = 3'd3;
  localparam logic [2:0] MF_DIV    = 3'd4;
  localparam logic [2:0] MF_DIVU   = 3'd5;
  localparam logic [2:0] MF_REM    = 3'd6;
  localparam logic [2:0] MF_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // operand selects
  localparam logic [1:0] SRCA_REG1  = 2'b00;
  localparam logic [1:0] SRCA_ZERO  = 2'b01;
  localparam logic [1:0] SRCA_PC    = 2'b10;
  localparam logic [1:0] SRCB_REG2  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_SHAMT = 2'b10;

  // Alu operations
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  // branch conditions (funct3 encoding)
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/exu_mc_if.sv
// IDU -> EXU -> WBU bus of the multi-cycle execute stage.
// master: IDU/WBU side (drives op fields, in_valid, out_ready).
// slave : execute stage (drives in_ready, out_valid, result, busy).
interface exu_mc_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_srca;
  logic [1:0]      alu_srcb;
  logic [3:0]      alu_ctrl;
  logic            m_op;
  logic [2:0]      m_funct;
  logic [XLEN-1:0] data_reg1;
  logic [XLEN-1:0] data_reg2;
  logic [XLEN-1:0] ext_imm;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, alu_srca, alu_srcb, alu_ctrl, m_op, m_funct,
           data_reg1, data_reg2, ext_imm, pc, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, alu_srca, alu_srcb, alu_ctrl, m_op, m_funct,
           data_reg1, data_reg2, ext_imm, pc, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV M-extension unit: shift-add multiplier / restoring divider,
// one bit per cycle over a 2*XLEN accumulator.
// Ports: clk, rst_n, flush; start + funct/opa/opb (sampled on start in IDLE);
// busy (registered, high while iterating); idle_c, done_c (done_c high in
// FIN while res_c carries the sign-corrected result).
module muldiv_iter
  import exu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            idle_c,
  output logic            done_c,
  output logic [XLEN-1:0] res_c
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned AW    = 2 * XLEN;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc, acc_step;
  logic [XLEN-1:0]  dvs;
  logic [2:0]       fn;
  logic             neg, rneg;

  logic             sa, sb;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [XLEN:0]    sum, top, diff;
  logic [AW-1:0]    prod;
  logic [XLEN-1:0]  quo, rem;

  // operand signedness and magnitudes
  always_comb begin : operand_sign
    sa = 1'b0;
    sb = 1'b0;
    case (funct)
      MF_MULH, MF_DIV, MF_REM: begin
        sa = opa[XLEN-1];
        sb = opb[XLEN-1];
      end
      MF_MULHSU: sa = opa[XLEN-1];
      default: ;
    endcase
    mag_a = sa ? -opa : opa;
    mag_b = sb ? -opb : opb;
  end

  // one iteration; dvs is the multiplicand or the divisor
  always_comb begin : step
    sum  = {1'b0, acc[AW-1:XLEN]} + {1'b0, dvs};
    // partial remainder shifted left with the next dividend bit appended
    top  = acc[AW-1:XLEN-1];
    diff = top - {1'b0, dvs};
    if (fn[2]) begin
      acc_step = diff[XLEN] ? {top[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[AW-1:1]};
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin : next_state
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_CALC;
        S_CALC:  if (cnt == CNT_W'(1)) state_nxt = S_FIN;
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // accumulator, counter and latched op attributes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      dvs  <= '0;
      fn   <= '0;
      neg  <= 1'b0;
      rneg <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      busy <= (state_nxt == S_CALC);
      if (flush) begin
        cnt <= '0;
      end else if (state == S_IDLE && start) begin
        // multiply is commutative, so mag_a can sit in the low half for both
        acc  <= {{XLEN{1'b0}}, mag_a};
        dvs  <= mag_b;
        fn   <= funct;
        neg  <= sa ^ sb;
        rneg <= sa;
        cnt  <= CNT_W'(XLEN);
      end else if (state == S_CALC) begin
        acc <= acc_step;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // outputs: sign fixup and half/quotient/remainder select
  always_comb begin : outputs
    idle_c = 1'b0;
    done_c = 1'b0;
    prod   = neg ? -acc : acc;
    quo    = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem    = rneg ? -acc[AW-1:XLEN] : acc[AW-1:XLEN];
    case (state)
      S_IDLE:  idle_c = 1'b1;
      S_FIN:   done_c = 1'b1;
      default: ;
    endcase
    if (fn[2])                res_c = fn[1] ? rem : quo;
    else if (fn[1:0] == 2'b00) res_c = prod[XLEN-1:0];
    else                      res_c = prod[AW-1:XLEN];
  end

endmodule

// File: rtl/exu_mc.sv
// Multi-cycle execute stage: combinational Alu plus iterative M unit behind
// a registered, back-pressurable result.
// Ports: clk, rst_n (async, active low), flush (synchronous abort),
// bus (exu_mc_if.slave): op fields + in_valid/in_ready from IDU,
// result/out_valid/out_ready to WBU, busy while the M unit iterates.
// XLEN must match the connected interface and be 32 or 64.
module exu_mc
  import exu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  exu_mc_if.slave      bus
);

  localparam int unsigned SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic            in_ready, accept, imm_op, md_start;
  logic            md_busy, md_idle_c, md_done_c;
  logic [XLEN-1:0] md_res_c;
  logic [XLEN-1:0] alu_a, alu_b, alu_res, imm_res;
  logic [SH_W-1:0] shamt;
  logic            div_zero, div_ovf, special;
  logic            out_valid;
  logic [XLEN-1:0] result;

  // operand muxes (Alu ops only)
  always_comb begin : src_mux
    alu_a = '0;
    alu_b = bus.data_reg2;
    case (bus.alu_srca)
      SRCA_REG1: alu_a = bus.data_reg1;
      SRCA_PC:   alu_a = bus.pc;
      default:   alu_a = '0;
    endcase
    case (bus.alu_srcb)
      SRCB_IMM:   alu_b = bus.ext_imm;
      SRCB_SHAMT: alu_b = bus.data_reg2 & XLEN'(XLEN - 1);
      default:    alu_b = bus.data_reg2;
    endcase
  end

  assign shamt = alu_b[SH_W-1:0];

  // Alu
  always_comb begin : alu
    alu_res = '0;
    case (bus.alu_ctrl)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << shamt;
      ALU_SLT:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU: alu_res = XLEN'(alu_a < alu_b);
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SRL:  alu_res = alu_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(alu_a) >>> shamt);
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_LUI:  alu_res = alu_b;
      default:  alu_res = '0;
    endcase
  end

  // divide special cases finish in one edge without iterating
  always_comb begin : m_special
    div_zero = (bus.data_reg2 == '0);
    div_ovf  = !bus.m_funct[0] && (bus.data_reg1 == MIN_INT) && (bus.data_reg2 == '1);
    special  = bus.m_funct[2] && (div_zero || div_ovf);
    imm_res  = alu_res;
    if (bus.m_op) begin
      if (div_zero) imm_res = bus.m_funct[1] ? bus.data_reg1 : '1;
      else          imm_res = bus.m_funct[1] ? '0 : bus.data_reg1;
    end
  end

  // rst_n term holds in_ready low while reset is asserted
  assign in_ready = rst_n && md_idle_c && (!out_valid || bus.out_ready) && !flush;
  assign accept   = bus.in_valid && in_ready;
  assign imm_op   = !bus.m_op || special;
  assign md_start = accept && bus.m_op && !special;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (md_start),
    .funct  (bus.m_funct),
    .opa    (bus.data_reg1),
    .opb    (bus.data_reg2),
    .busy   (md_busy),
    .idle_c (md_idle_c),
    .done_c (md_done_c),
    .res_c  (md_res_c)
  );

  // output register; a load replaces a same-cycle consume without a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (md_done_c) begin
      out_valid <= 1'b1;
      result    <= md_res_c;
    end else if (accept && imm_op) begin
      out_valid <= 1'b1;
      result    <= imm_res;
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.busy      = md_busy;

endmodule

// File: tb/tb_exu_mc.sv
// Directed bench for exu_mc (XLEN=32): vector table of single ops plus
// hand sequences for back-pressure, flush and reset during iteration.
module tb_exu_mc;
  import exu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  exu_mc_if #(.XLEN(XLEN)) bus ();

  exu_mc #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  srca;
    logic [1:0]  srcb;
    logic [3:0]  ctrl;
    logic        m;
    logic [2:0]  fn;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] exp;
    int          wait_e;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_alu(input logic [1:0] sa, input logic [1:0] sb,
                                  input logic [3:0] ctrl, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [31:0] imm,
                                  input logic [31:0] pc, input logic [31:0] exp);
    vec_t v;
    v.srca = sa; v.srcb = sb; v.ctrl = ctrl; v.m = 1'b0; v.fn = 3'd0;
    v.r1 = r1; v.r2 = r2; v.imm = imm; v.pc = pc; v.exp = exp; v.wait_e = 0;
    return v;
  endfunction

  function automatic vec_t mk_m(input logic [2:0] fn, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] exp,
                                input int wait_e);
    vec_t v;
    // Alu selects point away from rs1/rs2 so a wrong mux choice shows up
    v.srca = SRCA_PC; v.srcb = SRCB_IMM; v.ctrl = ALU_ADD; v.m = 1'b1; v.fn = fn;
    v.r1 = r1; v.r2 = r2; v.imm = 32'h0000_0999; v.pc = 32'h0000_0777;
    v.exp = exp; v.wait_e = wait_e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.alu_srca  = v.srca;
    bus.alu_srcb  = v.srcb;
    bus.alu_ctrl  = v.ctrl;
    bus.m_op      = v.m;
    bus.m_funct   = v.fn;
    bus.data_reg1 = v.r1;
    bus.data_reg2 = v.r2;
    bus.ext_imm   = v.imm;
    bus.pc        = v.pc;
  endtask

  task automatic scramble();
    bus.in_valid  = 1'b0;
    bus.alu_srca  = SRCA_ZERO;
    bus.alu_srcb  = SRCB_REG2;
    bus.alu_ctrl  = ALU_XOR;
    bus.m_op      = 1'b0;
    bus.m_funct   = MF_REMU;
    bus.data_reg1 = 32'hDEAD_BEEF;
    bus.data_reg2 = 32'h0;
    bus.ext_imm   = 32'h5555_AAAA;
    bus.pc        = 32'hFFFF_0000;
  endtask

  // issue one op with out_ready=1 and measure edges until out_valid
  task automatic run_vec(input vec_t v, input string tag);
    int edges;
    int busy_n;
    int rdy_hi;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    scramble();
    edges = 0; busy_n = 0; rdy_hi = 0;
    while (!bus.out_valid && edges < 100) begin
      if (bus.busy) busy_n++;
      if (bus.in_ready) rdy_hi++;
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, " result"}, bus.result, v.exp);
    chk({tag, " edges after accept"}, 32'(edges), 32'(v.wait_e));
    chk({tag, " in_ready with result"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " busy with result"}, 32'(bus.busy), 32'd0);
    if (v.wait_e != 0) begin
      chk({tag, " busy cycles"}, 32'(busy_n), 32'd32);
      chk({tag, " in_ready during calc"}, 32'(rdy_hi), 32'd0);
    end
  endtask

  // accept DIVU 100/3, let k more edges pass, then abort
  task automatic start_divu(input int k);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    drive(mk_m(MF_DIVU, 32'd100, 32'd3, 32'd33, 33));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    scramble();
    chk("abort busy after accept", 32'(bus.busy), 32'd1);
    repeat (k) @(posedge clk);
  endtask

  task automatic watch_quiet(input string tag);
    int seen;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk({tag, " out_valid stays low"}, 32'(seen), 32'd0);
  endtask

  task automatic flush_test(input int k, input string tag);
    start_divu(k);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk({tag, " in_ready during flush"}, 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " out_valid after flush"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " busy after flush"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk({tag, " in_ready after flush"}, 32'(bus.in_ready), 32'd1);
    watch_quiet(tag);
    run_vec(mk_m(MF_DIVU, 32'd100, 32'd3, 32'd33, 33), {tag, " DIVU after"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    scramble();
    bus.out_ready = 1'b0;

    // reset state
    #12;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready after reset", 32'(bus.in_ready), 32'd1);

    vecs.push_back(mk_alu(SRCA_REG1, SRCB_IMM,   ALU_ADD,  32'd5, 32'd0, 32'd7, 32'd0, 32'd12));
    vecs.push_back(mk_alu(SRCA_REG1, SRCB_REG2,  ALU_SUB,  32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFE));
    vecs.push_back(mk_alu(SRCA_PC,   SRCB_IMM,   ALU_ADD,  32'd9, 32'd0, 32'd4, 32'h1000, 32'h1004));
    vecs.push_back(mk_alu(SRCA_ZERO, SRCB_IMM,   ALU_ADD,  32'd9, 32'd0, 32'hABC, 32'h1000, 32'hABC));
    vecs.push_back(mk_alu(SRCA_REG1, SRCB_SHAMT, ALU_SLL,  32'd1, 32'h23, 32'd0, 32'd0, 32'd8));
    vecs.push_back(mk_alu(SRCA_REG1, SRCB_REG2,  ALU_SRA,  32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'hF800_0000));
    vecs.push_back(mk_alu(SRCA_REG1, SRCB_REG2,  ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1));
    vecs.push_back(mk_alu(SRCA_REG1, SRCB_REG2,  ALU_SLT,  32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk_m(MF_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33));
    vecs.push_back(mk_m(MF_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33));
    vecs.push_back(mk_m(MF_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33));
    vecs.push_back(mk_m(MF_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33));
    vecs.push_back(mk_m(MF_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 33));
    vecs.push_back(mk_m(MF_MUL,    32'd3,         32'd4,         32'd12,        33));
    vecs.push_back(mk_m(MF_DIV,    32'h1234,      32'd0,         32'hFFFF_FFFF, 0));
    vecs.push_back(mk_m(MF_REMU,   32'h1234,      32'd0,         32'h1234,      0));
    vecs.push_back(mk_m(MF_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0));
    vecs.push_back(mk_m(MF_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0));
    vecs.push_back(mk_m(MF_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33));
    vecs.push_back(mk_m(MF_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33));
    vecs.push_back(mk_m(MF_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33));
    vecs.push_back(mk_m(MF_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33));
    vecs.push_back(mk_m(MF_DIVU,   32'd100,       32'd3,         32'd33,        33));
    vecs.push_back(mk_m(MF_REMU,   32'd100,       32'd3,         32'd1,         33));
    vecs.push_back(mk_m(MF_DIVU,   32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         33));
    vecs.push_back(mk_m(MF_REMU,   32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33));
    vecs.push_back(mk_m(MF_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // back-pressure: result holds, then consume and accept in one edge
    @(posedge clk);
    @(negedge clk);
    drive(mk_alu(SRCA_REG1, SRCB_IMM, ALU_ADD, 32'd5, 32'd0, 32'd7, 32'd0, 32'd12));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("bp first valid", 32'(bus.out_valid), 32'd1);
    chk("bp first result", bus.result, 32'd12);
    bus.data_reg1 = 32'd1;
    bus.ext_imm   = 32'd1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp hold result", bus.result, 32'd12);
      chk("bp hold valid", 32'(bus.out_valid), 32'd1);
      chk("bp hold in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("bp in_ready on release", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    scramble();
    chk("bp next valid", 32'(bus.out_valid), 32'd1);
    chk("bp next result", bus.result, 32'd2);

    flush_test(10, "flush mid");
    flush_test(32, "flush fin");

    // reset during iteration
    start_divu(10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst mid out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst mid busy", 32'(bus.busy), 32'd0);
    chk("rst mid in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst mid in_ready after", 32'(bus.in_ready), 32'd1);
    watch_quiet("rst mid");
    run_vec(mk_m(MF_DIVU, 32'd100, 32'd3, 32'd33, 33), "rst mid DIVU after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
